// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer.
// The entry struct below describes the default configuration; sipo_deser builds the same shape
// for whatever WORD_W it is given.
package sipo_pkg;

  localparam int unsigned WordWDefault = 8;
  localparam int unsigned DepthDefault = 4;

  typedef enum logic {
    LsbFirst = 1'b0,
    MsbFirst = 1'b1
  } bit_order_e;

  typedef struct packed {
    logic [WordWDefault-1:0]         data;
    logic [$clog2(WordWDefault+1)-1:0] nbits;
    logic                            last;
  } sipo_entry_t;

  // Packed width of one FIFO entry {data, nbits, last} for a given word width.
  function automatic int unsigned entry_width(int unsigned word_w);
    return word_w + $clog2(word_w + 1) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter; push and pop may coincide at any fill level.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == (AddrW+1)'(Depth));
  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);
  // Head is forced to zero when empty so the outputs read zero out of reset.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AddrW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AddrW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer: packs accepted bits into words, realigns on sof_i,
// flushes zero-padded partial words and queues results in an output FIFO.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WORD_W    = WordWDefault,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned DEPTH     = DepthDefault,
  parameter int unsigned CNT_W     = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_serial_i,
  input  logic              valid_serial_i,
  output logic              ready_serial_o,
  input  logic              sof_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] data_o,
  output logic [CNT_W-1:0]  nbits_o,
  output logic              last_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sync_err_o
);

  localparam bit_order_e  Order  = MSB_FIRST ? MsbFirst : LsbFirst;
  localparam int unsigned EntryW = entry_width(WORD_W);

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  nbits;
    logic              last;
  } entry_t;

  logic [WORD_W-1:0] sr_q, sr_d, sr_base, sr_n;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base, cnt_n, pad;
  logic              flush_pend_q, flush_pend_d;
  logic              sync_err_q, sync_err_d;
  logic              accept, word_done, flush_req, push, fifo_full, fifo_valid;
  entry_t            push_entry, head;
  logic [EntryW-1:0] fifo_rdata;

  assign ready_serial_o = ~fifo_full & ~flush_pend_q;
  assign accept         = valid_serial_i & ready_serial_o;

  always_comb begin
    sr_base    = sr_q;
    cnt_base   = cnt_q;
    sync_err_d = 1'b0;
    // A qualified sof drops whatever was collected before the new bit is packed.
    if (accept && sof_i) begin
      sr_base    = '0;
      cnt_base   = '0;
      sync_err_d = (cnt_q != '0);
    end

    sr_n  = sr_base;
    cnt_n = cnt_base;
    if (accept) begin
      if (Order == MsbFirst) sr_n = {sr_base[WORD_W-2:0], data_serial_i};
      else                   sr_n = {data_serial_i, sr_base[WORD_W-1:1]};
      cnt_n = cnt_base + CNT_W'(1);
    end

    word_done = accept && (cnt_n == CNT_W'(WORD_W));
    flush_req = (flush_i | flush_pend_q) && (cnt_n != '0);

    // Justify so the first bit sits where it would in a full word.
    pad              = CNT_W'(WORD_W) - cnt_n;
    push_entry.data  = (Order == MsbFirst) ? (sr_n << pad) : (sr_n >> pad);
    push_entry.nbits = cnt_n;
    push_entry.last  = flush_req;

    push         = 1'b0;
    sr_d         = sr_n;
    cnt_d        = cnt_n;
    flush_pend_d = 1'b0;
    if (word_done || flush_req) begin
      if (fifo_full) begin
        flush_pend_d = 1'b1;
      end else begin
        push  = 1'b1;
        sr_d  = '0;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      sync_err_q   <= sync_err_d;
    end
  end

  sync_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (push_entry),
    .full_o  (fifo_full),
    .pop_i   (ready_i),
    .data_o  (fifo_rdata),
    .valid_o (fifo_valid)
  );

  assign head       = entry_t'(fifo_rdata);
  assign data_o     = head.data;
  assign nbits_o    = head.nbits;
  assign last_o     = head.last;
  assign valid_o    = fifo_valid;
  assign sync_err_o = sync_err_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: LSB-first and MSB-first instances share one stimulus stream and are
// checked every cycle against a bit-list / word-queue reference model.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_s = 1'b0, valid_s = 1'b0, sof = 1'b0, flush = 1'b0, ready = 1'b0;
  logic [7:0] data_l, data_m;
  logic [3:0] nb_l, nb_m;
  logic       last_l, last_m, vo_l, vo_m, rs_l, rs_m, se_l, se_m;

  always #5 clk = ~clk;

  sipo_deser #(.WORD_W(8), .MSB_FIRST(1'b0), .DEPTH(4)) u_lsb (
    .clk (clk), .rst_n (rst_n), .data_serial_i (data_s), .valid_serial_i (valid_s),
    .ready_serial_o (rs_l), .sof_i (sof), .flush_i (flush), .data_o (data_l),
    .nbits_o (nb_l), .last_o (last_l), .valid_o (vo_l), .ready_i (ready), .sync_err_o (se_l)
  );

  sipo_deser #(.WORD_W(8), .MSB_FIRST(1'b1), .DEPTH(4)) u_msb (
    .clk (clk), .rst_n (rst_n), .data_serial_i (data_s), .valid_serial_i (valid_s),
    .ready_serial_o (rs_m), .sof_i (sof), .flush_i (flush), .data_o (data_m),
    .nbits_o (nb_m), .last_o (last_m), .valid_o (vo_m), .ready_i (ready), .sync_err_o (se_m)
  );

  typedef struct {
    logic [7:0] dl;
    logic [7:0] dm;
    logic [3:0] nbits;
    logic       last;
  } ent_t;

  int   compared = 0, mismatched = 0;
  bit   pend[$];
  ent_t expq[$];
  int   occ;
  bit   fpend, sync_exp, last_acc;
  int   dut_pops = 0, dut_syncs = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t build(bit lastf);
    ent_t e;
    e.dl = '0;
    e.dm = '0;
    foreach (pend[i]) begin
      e.dl[i]     = pend[i];
      e.dm[7 - i] = pend[i];
    end
    e.nbits = 4'(pend.size());
    e.last  = lastf;
    return e;
  endfunction

  task automatic model_reset();
    pend.delete();
    expq.delete();
    occ      = 0;
    fpend    = 1'b0;
    sync_exp = 1'b0;
    last_acc = 1'b0;
  endtask

  // Advances the model by one clock using the inputs that were stable across the edge.
  task automatic model_step();
    bit rdy, pop, acc, fl;
    rdy      = (occ < 4) && !fpend;
    pop      = (occ > 0) && ready;
    acc      = valid_s && rdy;
    sync_exp = 1'b0;
    last_acc = acc;
    if (acc) begin
      if (sof) begin
        sync_exp = (pend.size() != 0);
        pend.delete();
      end
      pend.push_back(data_s);
    end
    if (pop) begin
      void'(expq.pop_front());
      occ--;
    end
    fl = (flush || fpend) && (pend.size() > 0);
    if (pend.size() == 8 || fl) begin
      if (occ == 4 && !pop) begin
        fpend = 1'b1;
      end else if (occ - (pop ? 0 : 0) >= 4 && pop) begin
        fpend = 1'b1;
      end else begin
        expq.push_back(build(fl));
        occ++;
        pend.delete();
        fpend = 1'b0;
      end
    end else begin
      fpend = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("ready_serial_lsb", rs_l, (occ < 4) && !fpend);
    chk("ready_serial_msb", rs_m, (occ < 4) && !fpend);
    chk("valid_lsb", vo_l, occ > 0);
    chk("valid_msb", vo_m, occ > 0);
    chk("sync_err_lsb", se_l, sync_exp);
    chk("sync_err_msb", se_m, sync_exp);
    if (occ > 0) begin
      chk("data_lsb", data_l, expq[0].dl);
      chk("data_msb", data_m, expq[0].dm);
      chk("nbits_lsb", nb_l, expq[0].nbits);
      chk("nbits_msb", nb_m, expq[0].nbits);
      chk("last_lsb", last_l, expq[0].last);
      chk("last_msb", last_m, expq[0].last);
    end
  endtask

  task automatic cycle();
    if (vo_l && ready) dut_pops++;
    @(posedge clk);
    #1;
    if (se_l) dut_syncs++;
    model_step();
    check_outputs();
  endtask

  task automatic send_bit(bit b, bit s);
    data_s  = b;
    valid_s = 1'b1;
    sof     = s;
    last_acc = 1'b0;
    for (int n = 0; n < 60; n++) begin
      cycle();
      if (last_acc) break;
    end
    chk("send_accepted", last_acc, 1'b1);
    valid_s = 1'b0;
    sof     = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    bit t1_bits[8];
    bit bits40[40];
    bit sof_bits[7];
    int p0, s0;

    t1_bits  = '{1, 0, 1, 1, 0, 0, 1, 0};
    sof_bits = '{1, 0, 0, 1, 1, 0, 1};
    model_reset();

    // Reset values
    #12;
    chk("rst_valid_lsb", vo_l, 1'b0);
    chk("rst_valid_msb", vo_m, 1'b0);
    chk("rst_data_lsb", data_l, 8'h00);
    chk("rst_nbits_lsb", nb_l, 4'd0);
    chk("rst_last_lsb", last_l, 1'b0);
    chk("rst_sync_lsb", se_l, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready_lsb", rs_l, 1'b1);
    chk("rst_ready_msb", rs_m, 1'b1);

    // Full word, both bit orders
    ready = 1'b1;
    foreach (t1_bits[i]) send_bit(t1_bits[i], 1'b0);
    chk("word_valid", vo_l, 1'b1);
    chk("word_lsb", data_l, 8'h4D);
    chk("word_msb", data_m, 8'hB2);
    chk("word_nbits", nb_l, 4'd8);
    chk("word_last", last_l, 1'b0);
    cycle();

    // Partial word flush
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    do_flush();
    chk("flush_lsb", data_l, 8'h03);
    chk("flush_msb", data_m, 8'hC0);
    chk("flush_nbits", nb_m, 4'd3);
    chk("flush_last", last_m, 1'b1);
    cycle();

    // Consumer stall fills the FIFO, then drains in order
    ready = 1'b0;
    foreach (bits40[i]) bits40[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 32; i++) send_bit(bits40[i], 1'b0);
    data_s  = bits40[32];
    valid_s = 1'b1;
    repeat (5) cycle();
    chk("stall_ready_low", rs_l, 1'b0);
    p0    = dut_pops;
    ready = 1'b1;
    for (int i = 32; i < 40; i++) send_bit(bits40[i], 1'b0);
    repeat (8) cycle();
    chk("stall_drain_count", dut_pops - p0, 5);

    // Start-of-frame realignment
    p0 = dut_pops;
    s0 = dut_syncs;
    repeat (5) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    foreach (sof_bits[i]) send_bit(sof_bits[i], 1'b0);
    chk("sof_word_lsb", data_l, 8'hB2);
    chk("sof_word_msb", data_m, 8'h4D);
    repeat (3) cycle();
    chk("sof_sync_pulses", dut_syncs - s0, 1);
    chk("sof_words", dut_pops - p0, 1);

    // Flush of a 5-bit partial into the last free slot, then flush with nothing pending
    ready = 1'b0;
    for (int i = 0; i < 29; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    chk("near_full_ready", rs_l, 1'b1);
    do_flush();
    chk("after_flush_ready", rs_l, 1'b0);
    do_flush();
    ready = 1'b1;
    repeat (6) cycle();

    // Asynchronous reset mid-word
    ready = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    chk("prereset_valid", vo_l, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_lsb", vo_l, 1'b0);
    chk("midrst_valid_msb", vo_m, 1'b0);
    chk("midrst_data_lsb", data_l, 8'h00);
    chk("midrst_nbits_msb", nb_m, 4'd0);
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    chk("postrst_valid", vo_l, 1'b1);
    cycle();

    // Random traffic; a stalled bit is held by the source until taken
    last_acc = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!valid_s || last_acc) begin
        valid_s = 1'($urandom_range(0, 1));
        data_s  = 1'($urandom_range(0, 1));
        sof     = ($urandom_range(0, 15) == 0);
      end
      flush = ($urandom_range(0, 11) == 0);
      ready = ($urandom_range(0, 1) == 1);
      cycle();
    end
    valid_s = 1'b0;
    flush   = 1'b0;
    ready   = 1'b1;
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
